// File: rtl/streamif_page_reader_pkg.sv
// Shared types and constants for the StreamIF page reader.
package streamif_pkg;

  localparam int unsigned STREAMIF_PAGE_SHIFT = 12;
  localparam int unsigned STREAMIF_PAGE_BYTES = 4096;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StData,
    StDrain
  } state_e;

  // Number of data beats needed to cover one page at the given data width.
  function automatic int unsigned page_beats(input int unsigned page_bytes,
                                             input int unsigned data_width);
    return page_bytes / (data_width / 8);
  endfunction

endpackage

// File: rtl/streamif_page_reader_if.sv
// Control, memory-port and output-stream signals of one StreamIF read channel.
// The master modport is the page reader; slave is its environment.
interface streamif_page_reader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [31:0]           StreamIF_CTRL_Addr;
  logic                  StreamIF_CTRL_AddrValid;
  logic                  StreamIF_CTRL_Start;
  logic                  StreamIF_CTRL_Idle;
  logic [31:0]           MEM_ReqAddr;
  logic [7:0]            MEM_ReqLen;
  logic                  MEM_ReqValid;
  logic                  MEM_ReqReady;
  logic [DATA_WIDTH-1:0] MEM_RData;
  logic                  MEM_RValid;
  logic                  MEM_RLast;
  logic                  MEM_RReady;
  logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
  logic                  M_AXIS_TVALID;
  logic                  M_AXIS_TLAST;
  logic                  M_AXIS_TREADY;

  modport master (
    input  StreamIF_CTRL_Addr, StreamIF_CTRL_AddrValid, StreamIF_CTRL_Start,
    output StreamIF_CTRL_Idle,
    output MEM_ReqAddr, MEM_ReqLen, MEM_ReqValid,
    input  MEM_ReqReady,
    input  MEM_RData, MEM_RValid, MEM_RLast,
    output MEM_RReady,
    output M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST,
    input  M_AXIS_TREADY
  );

  modport slave (
    output StreamIF_CTRL_Addr, StreamIF_CTRL_AddrValid, StreamIF_CTRL_Start,
    input  StreamIF_CTRL_Idle,
    input  MEM_ReqAddr, MEM_ReqLen, MEM_ReqValid,
    output MEM_ReqReady,
    output MEM_RData, MEM_RValid, MEM_RLast,
    input  MEM_RReady,
    input  M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST,
    output M_AXIS_TREADY
  );
endinterface

// File: rtl/streamif_skid_buffer.sv
// Two-entry valid/ready register slice. Accepts whenever not full, so it
// sustains one beat per cycle and absorbs one cycle of downstream stall.
module streamif_skid_buffer #(
  parameter int unsigned Width = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             push;
  logic             pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/streamif_page_reader.sv
// StreamIF per-channel page reader: latches a page address, fetches the page
// in bursts and streams it out with TLAST on the final beat.
// Optional STREAMIF_READER_RLAST_CHECK_EN: flag MEM_RLast disagreeing with the
// internal burst beat counter on the sticky Err output.
module streamif_page_reader
  import streamif_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned PAGE_BYTES = STREAMIF_PAGE_BYTES
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  streamif_page_reader_if.master bus,
  output logic                   Err
);

  localparam int unsigned PageBeats = page_beats(PAGE_BYTES, DATA_WIDTH);
  localparam int unsigned Bursts    = PageBeats / BURST_LEN;
  localparam int unsigned BeatW     = $clog2(PageBeats) + 1;
  localparam int unsigned BurstW    = $clog2(Bursts) + 1;
  localparam int unsigned BlenW     = $clog2(BURST_LEN) + 1;

  localparam logic [31:0]       BurstBytes  = 32'(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [BeatW-1:0]  LastBeat    = BeatW'(PageBeats - 1);
  localparam logic [BurstW-1:0] LastBurst   = BurstW'(Bursts - 1);
  localparam logic [BlenW-1:0]  LastInBurst = BlenW'(BURST_LEN - 1);

  state_e              state_q;
  logic                start_q;
  logic                addr_loaded_q;
  logic                idle_q;
  logic                req_valid_q;
  logic [31:0]         page_addr_q;
  logic [31:0]         req_addr_q;
  logic [BeatW-1:0]    beat_q;
  logic [BurstW-1:0]   burst_q;
  logic [BlenW-1:0]    in_burst_q;

  logic                start_edge;
  logic [31:0]         new_addr;
  logic                mem_fire;
  logic                out_fire;
  logic                skid_in_ready;
  logic                skid_out_valid;
  logic [DATA_WIDTH:0] skid_out_data;

  assign start_edge = bus.StreamIF_CTRL_Start & ~start_q;
  assign new_addr   = {bus.StreamIF_CTRL_Addr[31:STREAMIF_PAGE_SHIFT], 12'h000};
  assign mem_fire   = bus.MEM_RValid & bus.MEM_RReady;
  assign out_fire   = bus.M_AXIS_TVALID & bus.M_AXIS_TREADY;

  assign bus.StreamIF_CTRL_Idle = idle_q;
  assign bus.MEM_ReqAddr        = req_addr_q;
  assign bus.MEM_ReqLen         = 8'(BURST_LEN - 1);
  assign bus.MEM_ReqValid       = req_valid_q;
  assign bus.MEM_RReady         = (state_q == StData) & skid_in_ready;
  assign bus.M_AXIS_TDATA       = skid_out_data[DATA_WIDTH-1:0];
  assign bus.M_AXIS_TVALID      = skid_out_valid;
  // Gate TLAST so a stale stored flag never shows while the stream is idle.
  assign bus.M_AXIS_TLAST       = skid_out_valid & skid_out_data[DATA_WIDTH];

  streamif_skid_buffer #(
    .Width(DATA_WIDTH + 1)
  ) u_skid (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .in_data_i  ({beat_q == LastBeat, bus.MEM_RData}),
    .in_valid_i (bus.MEM_RValid & (state_q == StData)),
    .in_ready_o (skid_in_ready),
    .out_data_o (skid_out_data),
    .out_valid_o(skid_out_valid),
    .out_ready_i(bus.M_AXIS_TREADY)
  );

  // Page fetch FSM with registered Idle/ReqValid.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= StIdle;
      start_q       <= 1'b0;
      addr_loaded_q <= 1'b0;
      idle_q        <= 1'b1;
      req_valid_q   <= 1'b0;
      page_addr_q   <= '0;
      req_addr_q    <= '0;
      beat_q        <= '0;
      burst_q       <= '0;
      in_burst_q    <= '0;
    end else begin
      start_q <= bus.StreamIF_CTRL_Start;
      unique case (state_q)
        StIdle: begin
          if (bus.StreamIF_CTRL_AddrValid) begin
            page_addr_q   <= new_addr;
            addr_loaded_q <= 1'b1;
          end
          // An address presented in the same cycle as the edge wins.
          if (start_edge && (addr_loaded_q || bus.StreamIF_CTRL_AddrValid)) begin
            req_addr_q  <= bus.StreamIF_CTRL_AddrValid ? new_addr : page_addr_q;
            beat_q      <= '0;
            burst_q     <= '0;
            idle_q      <= 1'b0;
            req_valid_q <= 1'b1;
            state_q     <= StReq;
          end
        end
        StReq: begin
          if (bus.MEM_ReqReady) begin
            req_valid_q <= 1'b0;
            req_addr_q  <= req_addr_q + BurstBytes;
            in_burst_q  <= '0;
            state_q     <= StData;
          end
        end
        StData: begin
          if (mem_fire) begin
            beat_q     <= beat_q + 1'b1;
            in_burst_q <= in_burst_q + 1'b1;
            if (in_burst_q == LastInBurst) begin
              burst_q <= burst_q + 1'b1;
              if (burst_q == LastBurst) begin
                state_q <= StDrain;
              end else begin
                req_valid_q <= 1'b1;
                state_q     <= StReq;
              end
            end
          end
        end
        StDrain: begin
          // The TLAST beat is the last one queued, so its handshake empties the buffer.
          if (out_fire && bus.M_AXIS_TLAST) begin
            idle_q        <= 1'b1;
            addr_loaded_q <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef STREAMIF_READER_RLAST_CHECK_EN
  logic err_q;

  // Sticky flag: memory RLast disagrees with our own burst-end position.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_q <= 1'b0;
    end else if (mem_fire && (bus.MEM_RLast != (in_burst_q == LastInBurst))) begin
      err_q <= 1'b1;
    end
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_streamif_page_reader.sv
// Directed bench for streamif_page_reader: memory responder model, stream and
// request checkers, and a linear sequence of page-level scenarios.
module tb_streamif_page_reader;

  logic clk = 1'b0;
  logic rst;
  logic err;

  always #5 clk = ~clk;

  streamif_page_reader_if #(.DATA_WIDTH(32)) bus ();

  streamif_page_reader #(
    .DATA_WIDTH(32),
    .BURST_LEN (16),
    .PAGE_BYTES(4096)
  ) dut (
    .ACLK  (clk),
    .ARESET(rst),
    .bus   (bus),
    .Err   (err)
  );

  int          checks   = 0;
  int          failures = 0;
  int          rx_total = 0;
  int          req_total = 0;
  int          rx_start = 0;
  int          req_start = 0;
  logic [31:0] exp_base = 32'h0;
  bit          bp_en = 1'b0;
  bit          inj_en = 1'b0;
  bit          chk_idle_next = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_page(input string tag);
    int n = 0;
    while (!((rx_total - rx_start) == 1024 && bus.StreamIF_CTRL_Idle === 1'b1) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(n >= 20000), 64'd0);
    chk({tag, "_beats"}, 64'(rx_total - rx_start), 64'd1024);
    chk({tag, "_reqs"}, 64'(req_total - req_start), 64'd64);
  endtask

  // Memory responder: one burst at a time, data = word address.
  logic [7:0]  m_len;
  logic [7:0]  m_beat;
  logic [31:0] m_base;
  bit          m_busy;
  bit          m_inj;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.MEM_RValid <= 1'b0;
      bus.MEM_RLast  <= 1'b0;
      bus.MEM_RData  <= '0;
      m_busy <= 1'b0;
      m_inj  <= 1'b0;
      m_len  <= '0;
      m_beat <= '0;
      m_base <= '0;
    end else if (!m_busy) begin
      if (bus.MEM_ReqValid && bus.MEM_ReqReady) begin
        m_busy <= 1'b1;
        m_len  <= bus.MEM_ReqLen;
        m_beat <= '0;
        m_base <= bus.MEM_ReqAddr >> 2;
        m_inj  <= inj_en && (bus.MEM_ReqAddr[11:0] == 12'h0C0);
        bus.MEM_RValid <= 1'b1;
        bus.MEM_RData  <= bus.MEM_ReqAddr >> 2;
        bus.MEM_RLast  <= (bus.MEM_ReqLen == 8'd0);
      end
    end else if (bus.MEM_RValid && bus.MEM_RReady) begin
      if (m_beat == m_len) begin
        m_busy <= 1'b0;
        bus.MEM_RValid <= 1'b0;
        bus.MEM_RLast  <= 1'b0;
      end else begin
        m_beat <= m_beat + 8'd1;
        bus.MEM_RData <= m_base + 32'(m_beat) + 32'd1;
        bus.MEM_RLast <= (m_beat + 8'd1 == m_len) || (m_inj && m_beat + 8'd1 == 8'd14);
      end
    end
  end

  // Downstream ready: always ready, or about 30% duty under backpressure.
  always @(posedge clk) begin
    #1;
    bus.M_AXIS_TREADY = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Request and stream checkers, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_idle_next) begin
        chk("idle_after_tlast", 64'(bus.StreamIF_CTRL_Idle), 64'd1);
        chk_idle_next = 1'b0;
      end
      if (bus.MEM_ReqValid && bus.MEM_ReqReady) begin
        chk("req_addr", 64'(bus.MEM_ReqAddr), 64'(exp_base + 32'((req_total - req_start) * 64)));
        chk("req_len", 64'(bus.MEM_ReqLen), 64'd15);
        req_total = req_total + 1;
      end
      if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
        chk("tdata", 64'(bus.M_AXIS_TDATA), 64'((exp_base >> 2) + 32'(rx_total - rx_start)));
        chk("tlast", 64'(bus.M_AXIS_TLAST), 64'((rx_total - rx_start) == 1023));
        if (bus.M_AXIS_TLAST) begin
          chk("idle_at_tlast", 64'(bus.StreamIF_CTRL_Idle), 64'd0);
          chk_idle_next = 1'b1;
        end
        rx_total = rx_total + 1;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.StreamIF_CTRL_Addr      = '0;
    bus.StreamIF_CTRL_AddrValid = 1'b0;
    bus.StreamIF_CTRL_Start     = 1'b0;
    bus.MEM_ReqReady            = 1'b1;
    tick(3);

    // Reset state.
    chk("rst_idle", 64'(bus.StreamIF_CTRL_Idle), 64'd1);
    chk("rst_reqvalid", 64'(bus.MEM_ReqValid), 64'd0);
    chk("rst_rready", 64'(bus.MEM_RReady), 64'd0);
    chk("rst_tvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
    chk("rst_tlast", 64'(bus.M_AXIS_TLAST), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_reqaddr", 64'(bus.MEM_ReqAddr), 64'd0);
    chk("rst_reqlen", 64'(bus.MEM_ReqLen), 64'd15);
    rst = 1'b0;
    tick(2);

    // Start edge with no address loaded: ignored.
    bus.StreamIF_CTRL_Start = 1'b1;
    tick(6);
    chk("noaddr_idle", 64'(bus.StreamIF_CTRL_Idle), 64'd1);
    chk("noaddr_reqs", 64'(req_total), 64'd0);
    bus.StreamIF_CTRL_Start = 1'b0;
    tick(2);

    // Basic page; low address bits are dropped.
    exp_base = 32'h1000_0000;
    rx_start = rx_total;
    req_start = req_total;
    bus.StreamIF_CTRL_Addr = 32'h1000_0ABC;
    bus.StreamIF_CTRL_AddrValid = 1'b1;
    tick(1);
    bus.StreamIF_CTRL_AddrValid = 1'b0;
    bus.StreamIF_CTRL_Addr = '0;
    bus.StreamIF_CTRL_Start = 1'b1;
    tick(1);
    chk("basic_idle_fall", 64'(bus.StreamIF_CTRL_Idle), 64'd0);
    chk("basic_reqvalid", 64'(bus.MEM_ReqValid), 64'd1);
    wait_page("basic");
    chk("basic_err", 64'(err), 64'd0);

    // Start still high after completion: no second page.
    tick(20);
    chk("held_reqs", 64'(req_total - req_start), 64'd64);
    chk("held_idle", 64'(bus.StreamIF_CTRL_Idle), 64'd1);
    bus.StreamIF_CTRL_Start = 1'b0;
    tick(1);

    // New address with the start edge in the same cycle, under backpressure.
    exp_base = 32'h2000_0000;
    rx_start = rx_total;
    req_start = req_total;
    bp_en = 1'b1;
    bus.StreamIF_CTRL_Addr = 32'h2000_0000;
    bus.StreamIF_CTRL_AddrValid = 1'b1;
    bus.StreamIF_CTRL_Start = 1'b1;
    tick(1);
    bus.StreamIF_CTRL_AddrValid = 1'b0;
    chk("bp_idle_fall", 64'(bus.StreamIF_CTRL_Idle), 64'd0);
    tick(50);
    // Address presented mid-page must not disturb the fetch.
    bus.StreamIF_CTRL_Addr = 32'h5000_0000;
    bus.StreamIF_CTRL_AddrValid = 1'b1;
    tick(1);
    bus.StreamIF_CTRL_AddrValid = 1'b0;
    wait_page("bp");
    bp_en = 1'b0;
    bus.StreamIF_CTRL_Start = 1'b0;
    tick(2);

    // Reset during burst 10.
    exp_base = 32'h3000_0000;
    rx_start = rx_total;
    req_start = req_total;
    bus.StreamIF_CTRL_Addr = 32'h3000_0000;
    bus.StreamIF_CTRL_AddrValid = 1'b1;
    tick(1);
    bus.StreamIF_CTRL_AddrValid = 1'b0;
    bus.StreamIF_CTRL_Start = 1'b1;
    tick(1);
    bus.StreamIF_CTRL_Start = 1'b0;
    n = 0;
    while ((req_total - req_start) < 10 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reach_burst10", 64'(req_total - req_start), 64'd10);
    tick(3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_idle", 64'(bus.StreamIF_CTRL_Idle), 64'd1);
    chk("midrst_reqvalid", 64'(bus.MEM_ReqValid), 64'd0);
    chk("midrst_rready", 64'(bus.MEM_RReady), 64'd0);
    chk("midrst_tvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
    chk("midrst_tlast", 64'(bus.M_AXIS_TLAST), 64'd0);
    chk("midrst_reqaddr", 64'(bus.MEM_ReqAddr), 64'd0);
    tick(2);
    rst = 1'b0;
    rx_start = rx_total;
    req_start = req_total;
    tick(2);
    // Address flag was cleared by reset: a start edge alone does nothing.
    bus.StreamIF_CTRL_Start = 1'b1;
    tick(6);
    chk("postrst_idle", 64'(bus.StreamIF_CTRL_Idle), 64'd1);
    chk("postrst_reqs", 64'(req_total - req_start), 64'd0);
    bus.StreamIF_CTRL_Start = 1'b0;
    tick(2);

`ifdef STREAMIF_READER_RLAST_CHECK_EN
    // Early RLast on beat 14 of burst 3: Err latches, stream unaffected.
    exp_base = 32'h4000_0000;
    rx_start = rx_total;
    req_start = req_total;
    inj_en = 1'b1;
    bus.StreamIF_CTRL_Addr = 32'h4000_0000;
    bus.StreamIF_CTRL_AddrValid = 1'b1;
    bus.StreamIF_CTRL_Start = 1'b1;
    tick(1);
    bus.StreamIF_CTRL_AddrValid = 1'b0;
    wait_page("rlast");
    chk("rlast_err", 64'(err), 64'd1);
    tick(5);
    chk("rlast_err_sticky", 64'(err), 64'd1);
    inj_en = 1'b0;
    bus.StreamIF_CTRL_Start = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/streamif_page_reader.md
# streamif_page_reader

Per-channel StreamIF read endpoint: the responder to the StreamIF control block's per-channel `Addr`/`AddrValid`/`Start`/`Idle` lines. It latches a 4096-byte-aligned page address, and on a start request fetches the whole page through burst reads on a simple memory request/response port. It presents the page as an AXI4-Stream master with `TLAST` on the final beat. One instance sits behind each hardware thread's read channel.

## Interface
- `DATA_WIDTH`, 32, memory and stream data width in bits; legal values are 32 and 64.
- `BURST_LEN`, 16, beats per memory burst; must be a power of 2 that divides the page beat count.
- `PAGE_BYTES`, 4096, bytes fetched per start; fixed by the control address alignment.
- `ACLK` in 1, single clock for all logic.
- `ARESET` in 1, asynchronous, active-high reset.
- `StreamIF_CTRL_Addr` in 32, page address; only bits [31:12] are used.
- `StreamIF_CTRL_AddrValid` in 1, level; while high in IDLE, the address is captured.
- `StreamIF_CTRL_Start` in 1, level from a software-written register bit; the block acts on its rising edge.
- `StreamIF_CTRL_Idle` out 1, high when the block is ready for a new page.
- `MEM_ReqAddr` out 32, byte address of the burst.
- `MEM_ReqLen` out 8, burst length minus 1.
- `MEM_ReqValid` out 1 / `MEM_ReqReady` in 1, valid/ready handshake for the request.
- `MEM_RData` in DATA_WIDTH, `MEM_RValid` in 1, `MEM_RLast` in 1, `MEM_RReady` out 1, read-data beat handshake.
- `M_AXIS_TDATA` out DATA_WIDTH, `M_AXIS_TVALID` out 1, `M_AXIS_TLAST` out 1, `M_AXIS_TREADY` in 1, output stream.
- `Err` out 1, sticky protocol error flag; see Configuration.

## Operation
- Reset values: `Idle`=1, `MEM_ReqValid`=0, `MEM_RReady`=0, `TVALID`=0, `TLAST`=0, `Err`=0, `MEM_ReqAddr`=0, `MEM_ReqLen`=`BURST_LEN`-1.
- Reset also clears the address register, the `addr_loaded` flag and `start_q`.
- Page beats: `PAGE_BEATS` = `PAGE_BYTES`/(`DATA_WIDTH`/8). Bursts per page: `PAGE_BEATS`/`BURST_LEN`.
- States:
  - IDLE: `Idle`=1. `AddrValid`=1 loads `page_addr` = {`Addr`[31:12], 12'h000} and sets `addr_loaded`. A start edge (`Start` & ~`start_q`) with `addr_loaded`=1 clears the beat and burst counters, sets `req_addr` = `page_addr`, and goes to REQ.
  - REQ: `MEM_ReqValid`=1. On `ReqReady`, go to DATA.
  - DATA: forward beats through the skid buffer. On the last beat of a burst, go to REQ if more bursts remain; otherwise go to DRAIN. `req_addr` advances by `BURST_LEN`*`DATA_WIDTH`/8 when the request is accepted.
  - DRAIN: wait until the skid buffer is empty and the final beat has been accepted, then go to IDLE and clear `addr_loaded`.
- Only one burst is outstanding at a time.
- `MEM_RReady` = skid buffer not full, gated by state DATA.
- Beat counter is `log2(PAGE_BEATS)+1` bits wide. `TLAST` is set on beat `PAGE_BEATS`-1 only.
- Boundary conditions:
  - `AddrValid` outside IDLE: ignored.
  - Start edge without `addr_loaded`: ignored; `Idle` stays 1.
  - `Start` held high across completion: no retrigger. A new low→high transition is required.
  - `AddrValid` and a start edge in the same cycle: the new address is used.
  - `TREADY` low indefinitely: the skid buffer fills, `MEM_RReady` drops, and no data is lost.
  - Reset mid-page: immediate return to IDLE, and the page is abandoned. The memory side must be reset together with this block.

## Timing
- `Start` rises at cycle N. `start_q` is sampled at N and the edge is registered. `Idle` falls and `MEM_ReqValid` rises at N+1.
- Request to data: `MEM_RReady` is high in the first DATA cycle.
- Skid buffer latency: a beat accepted at cycle M appears on `TVALID` at M+1. Full throughput is one beat per cycle with `TREADY`=1.
- Next request: `ReqValid` is asserted the cycle after the burst's last beat is accepted.
- `Idle` rises the cycle after the `TLAST` handshake.

## Configuration
- `STREAMIF_READER_RLAST_CHECK_EN` defined: each incoming beat's `MEM_RLast` is compared with (burst beat counter == `BURST_LEN`-1).
  - On mismatch, `Err` sets and holds until `ARESET`.
  - Data flow is unaffected; the internal counter stays authoritative for burst end.
- Undefined: `MEM_RLast` is ignored, `Err` is tied to 0, and no checker logic is synthesized.

## Structure
- Package `streamif_pkg`:
  - state enum (IDLE, REQ, DATA, DRAIN)
  - `STREAMIF_PAGE_SHIFT`=12 and `STREAMIF_PAGE_BYTES`=4096
  - beat-count helper function
- Sub-module `streamif_skid_buffer`: 2-entry valid/ready register slice, parameterised by width, carrying {`TLAST`, `TDATA`}.

## Test plan
- Basic page, default parameters (32-bit data, 16-beat bursts):
  - Stimulus: `Addr`=0x1000_0ABC with `AddrValid` high for 1 cycle, then a `Start` edge, memory model returns incrementing data.
  - Response: 64 requests, addresses 0x1000_0000 through 0x1000_0FC0 in steps of 0x40, all `ReqLen`=15.
  - Response: 1024 stream beats in order, `TLAST` only on beat 1023.
  - Response: `Idle` is 0 from the cycle after the edge and returns to 1 one cycle after the last beat.
- Backpressure: `TREADY` toggles randomly at 30% duty -> identical 1024-beat sequence, with no drops and no duplicates.
- Start without a loaded address, straight after reset -> no `MEM_ReqValid`; `Idle` stays 1.
- `Start` held high through completion -> exactly one page is fetched; after low then high, a second page is fetched from the newly loaded address 0x2000_0000.
- Reset mid-page: `ARESET` asserted during burst 10 -> all outputs take their reset values asynchronously; after release, `Idle`=1 and `addr_loaded`=0.
- With `STREAMIF_READER_RLAST_CHECK_EN`: the memory model asserts `RLast` on beat 14 of burst 3 -> `Err`=1 and stays high; the stream still delivers 1024 beats.
